nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequential controller that adds two wide operands by driving a single external 4-bit ripple-carry adder one nibble per clock, least-significant nibble first. It registers the carry between nibbles and accumulates the sum. It sits directly upstream and downstream of the 4-bit adder: it feeds the adder's operand and carry-in pins and captures the adder's sum and carry-out. It trades latency for area against a fully parallel 8-bit adder built from two 4-bit stages.

## Interface
- NIBBLES, 2, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request to begin an addition; sampled only when not busy
- op_a  input  W  operand A; sampled in the cycle start is accepted
- op_b  input  W  operand B; sampled in the cycle start is accepted
- c_in  input  1  carry into nibble 0; sampled with op_a/op_b
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; result and c_out are valid from this cycle on
- result  output  W  accumulated sum
- c_out  output  1  carry out of the top nibble
- add_a  output  4  operand A nibble to the external 4-bit adder
- add_b  output  4  operand B nibble to the external 4-bit adder
- add_cin  output  1  carry-in to the external adder
- add_sum  input  4  sum from the external adder; combinational from add_a/add_b/add_cin
- add_cout  input  1  carry-out from the external adder

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE or DONE with start=1:**
  - latch op_a, op_b and c_in into a_reg, b_reg and carry_reg
  - idx <= 0; result <= 0; c_out <= 0
  - next state RUN
- **IDLE or DONE with start=0:**
  - hold all registers
  - DONE moves to IDLE
- **RUN:**
  - add_a = a_reg[4*idx+3:4*idx]; add_b = b_reg nibble idx; add_cin = carry_reg
  - at each edge: result nibble idx <= add_sum; carry_reg <= add_cout
  - if idx == NIBBLES-1: c_out <= add_cout and next state DONE; otherwise idx <= idx+1
- **DONE:** done = 1 for exactly this cycle.
- busy = 1 only in RUN.
- start is ignored in RUN; no queuing.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Arithmetic is unsigned modulo 2^W. The full result is {c_out, result} = op_a + op_b + c_in.
- The block places no constraint on the external adder beyond a combinational path that settles within one clk period.
- result and c_out hold their last values until the next accepted start.
- result is not meaningful while busy=1; partial nibbles are visible.

## Timing
- Reset values: busy=0, done=0, result=0, c_out=0, add_a=0, add_b=0, add_cin=0, state IDLE, idx=0.
- Latency:
  - start is accepted at edge E0
  - RUN occupies cycles E0..E0+NIBBLES
  - done is high in the cycle after edge E0+NIBBLES
  - for NIBBLES=2, done is high 3 cycles after start is sampled
- Throughput: one addition per NIBBLES+1 cycles. start asserted during the DONE cycle is accepted, giving back-to-back operation with no idle gap.
- Reset asserted in any state, including mid-RUN, takes priority over start. The next cycle is IDLE with all outputs at reset values, and the partial result is discarded.
- If start and reset are high together, reset wins and the operation is not accepted.
- NIBBLES=1 gives RUN for exactly one cycle. The wrap of idx never occurs because RUN exits at NIBBLES-1.

## Test plan
- Basic add (NIBBLES=2): start with op_a=0x3C, op_b=0x5A, c_in=0.
  - Required: busy for 2 cycles, add_a=0xC/add_b=0xA then add_a=0x3/add_b=0x5, carry 1 propagated via add_cin.
  - Then done pulse with result=0x96, c_out=0.
- Full carry ripple: op_a=0xFF, op_b=0x01, c_in=0 -> result=0x00, c_out=1.
  - Also op_a=0xFF, op_b=0x00, c_in=1 -> result=0x00, c_out=1.
  - Also op_a=0x00, op_b=0x00, c_in=0 -> result=0x00, c_out=0.
- Start during busy: start with 0x11+0x22, then pulse start with 0xFF+0xFF while busy.
  - Required: the second request is ignored and done shows result=0x33, c_out=0.
- Back-to-back: hold start high with 0x10+0x20 then 0x0F+0x01, presenting the second set on the done cycle.
  - Required: done pulses 3 cycles apart, with result=0x30 then 0x10.
- Reset mid-run: start 0xAA+0x55, assert reset after the first RUN cycle.
  - Required: next cycle busy=0, done=0, result=0x00, c_out=0, and add_* are 0.
  - A subsequent start with 0x01+0x01 yields result=0x02.
- Randomised check with NIBBLES=1 and NIBBLES=4: {c_out, result} equals op_a+op_b+c_in for 1000 random vectors, and done occurs NIBBLES+1 cycles after start.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: steps one external 4-bit ripple adder across the operands,
// least-significant nibble first, carrying between nibbles in a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= c_in;
            idx       <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            state     <= RUN;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Capture this nibble's sum; the carry-out feeds the next nibble.
          result[4*int'(idx) +: 4] <= add_sum;
          carry_reg                <= add_cout;
          if (idx == LAST) begin
            c_out <= add_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder pins are quiet outside RUN so the external adder sees zeros when idle.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[4*int'(idx) +: 4];
      add_b   = b_reg[4*int'(idx) +: 4];
      add_cin = carry_reg;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: three widths, each paired with a behavioural
// 4-bit adder, checked against plain-arithmetic expectations.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // NIBBLES = 2 instance
  logic        start2, cin2, busy2, done2, cout2, addcin2, addcout2;
  logic [7:0]  a2, b2, res2;
  logic [3:0]  adda2, addb2, addsum2;
  assign {addcout2, addsum2} = {1'b0, adda2} + {1'b0, addb2} + {4'b0, addcin2};

  nibble_serial_adder #(.NIBBLES(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .op_a(a2), .op_b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .result(res2), .c_out(cout2),
    .add_a(adda2), .add_b(addb2), .add_cin(addcin2),
    .add_sum(addsum2), .add_cout(addcout2)
  );

  // NIBBLES = 1 instance
  logic        start1, cin1, busy1, done1, cout1, addcin1, addcout1;
  logic [3:0]  a1, b1, res1;
  logic [3:0]  adda1, addb1, addsum1;
  assign {addcout1, addsum1} = {1'b0, adda1} + {1'b0, addb1} + {4'b0, addcin1};

  nibble_serial_adder #(.NIBBLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(a1), .op_b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .result(res1), .c_out(cout1),
    .add_a(adda1), .add_b(addb1), .add_cin(addcin1),
    .add_sum(addsum1), .add_cout(addcout1)
  );

  // NIBBLES = 4 instance
  logic        start4, cin4, busy4, done4, cout4, addcin4, addcout4;
  logic [15:0] a4, b4, res4;
  logic [3:0]  adda4, addb4, addsum4;
  assign {addcout4, addsum4} = {1'b0, adda4} + {1'b0, addb4} + {4'b0, addcin4};

  nibble_serial_adder #(.NIBBLES(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .op_a(a4), .op_b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .result(res4), .c_out(cout4),
    .add_a(adda4), .add_b(addb4), .add_cin(addcin4),
    .add_sum(addsum4), .add_cout(addcout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    start2 = 1'b1;
    a2     = a;
    b2     = b;
    cin2   = cin;
  endtask

  // Runs one NIBBLES=2 addition; returns the result seen on done and the
  // number of edges from acceptance until done is visible.
  task automatic runAdd2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [8:0] full, output int lat);
    applyStimulus(a, b, cin);
    tick();
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 20) begin
      tick();
      lat++;
    end
    full = {cout2, res2};
  endtask

  task automatic runAdd1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         output logic [4:0] full, output int lat);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
    tick();
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
    full = {cout1, res1};
  endtask

  task automatic runAdd4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [16:0] full, output int lat);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
    tick();
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    full = {cout4, res4};
  endtask

  logic [8:0]  full2;
  logic [4:0]  full1;
  logic [16:0] full4;
  logic [7:0]  va, vb;
  logic        vc;
  logic [15:0] wa, wb;
  logic [3:0]  na, nb;
  int          lat;
  int          gap;
  logic [8:0]  vecs [4];

  initial begin
    reset = 1'b1;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    tick();
    tick();
    reset = 1'b0;

    checkOutput("reset_busy", 32'(busy2), 32'd0);
    checkOutput("reset_done", 32'(done2), 32'd0);
    checkOutput("reset_result", 32'(res2), 32'd0);
    checkOutput("reset_cout", 32'(cout2), 32'd0);
    checkOutput("reset_addpins", 32'({adda2, addb2, addcin2}), 32'd0);

    // Basic add with per-nibble pin checks
    va = 8'h3C; vb = 8'h5A; vc = 1'b0;
    applyStimulus(va, vb, vc);
    tick();
    start2 = 1'b0;
    checkOutput("basic_busy0", 32'(busy2), 32'd1);
    checkOutput("basic_nib0", 32'({adda2, addb2, addcin2}), 32'({va[3:0], vb[3:0], vc}));
    tick();
    checkOutput("basic_busy1", 32'(busy2), 32'd1);
    checkOutput("basic_nib1", 32'({adda2, addb2, addcin2}),
                32'({va[7:4], vb[7:4], 1'(({1'b0, va[3:0]} + {1'b0, vb[3:0]} + 5'(vc)) >> 4)}));
    tick();
    checkOutput("basic_done", 32'({done2, busy2}), 32'b10);
    checkOutput("basic_sum", 32'({cout2, res2}), 32'(9'(va) + 9'(vb) + 9'(vc)));
    checkOutput("basic_sum_lit", 32'({cout2, res2}), 32'h096);
    checkOutput("done_addpins", 32'({adda2, addb2, addcin2}), 32'd0);
    tick();
    checkOutput("done_pulse_end", 32'(done2), 32'd0);
    checkOutput("result_hold", 32'({cout2, res2}), 32'h096);

    // Carry ripple vectors
    vecs[0] = {1'b0, 8'hFF}; vecs[1] = {1'b0, 8'h01};
    runAdd2(8'hFF, 8'h01, 1'b0, full2, lat);
    checkOutput("ripple_ff_01", 32'(full2), 32'h100);
    checkOutput("ripple_ff_01_lat", 32'(lat), 32'd3);
    runAdd2(8'hFF, 8'h00, 1'b1, full2, lat);
    checkOutput("ripple_ff_cin", 32'(full2), 32'h100);
    runAdd2(8'h00, 8'h00, 1'b0, full2, lat);
    checkOutput("ripple_zero", 32'(full2), 32'h000);
    tick();

    // Start during busy is ignored
    applyStimulus(8'h11, 8'h22, 1'b0);
    tick();
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    tick();
    start2 = 1'b0;
    tick();
    checkOutput("busy_ignore_done", 32'(done2), 32'd1);
    checkOutput("busy_ignore_sum", 32'({cout2, res2}), 32'h033);
    tick();
    checkOutput("busy_ignore_noqueue", 32'({done2, busy2}), 32'd0);

    // Back-to-back with start held high
    applyStimulus(8'h10, 8'h20, 1'b0);
    tick();
    gap = 1;
    while (!done2 && gap < 20) begin
      tick();
      gap++;
    end
    checkOutput("b2b_first", 32'({cout2, res2}), 32'h030);
    applyStimulus(8'h0F, 8'h01, 1'b0);
    tick();
    start2 = 1'b0;
    checkOutput("b2b_accepted", 32'(busy2), 32'd1);
    gap = 1;
    while (!done2 && gap < 20) begin
      tick();
      gap++;
    end
    checkOutput("b2b_gap", 32'(gap), 32'd3);
    checkOutput("b2b_second", 32'({cout2, res2}), 32'h010);
    tick();

    // Reset mid-run discards the partial result
    applyStimulus(8'hAA, 8'h55, 1'b0);
    tick();
    start2 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_flags", 32'({busy2, done2}), 32'd0);
    checkOutput("midreset_result", 32'({cout2, res2}), 32'd0);
    checkOutput("midreset_addpins", 32'({adda2, addb2, addcin2}), 32'd0);
    runAdd2(8'h01, 8'h01, 1'b0, full2, lat);
    checkOutput("after_reset_sum", 32'(full2), 32'h002);
    tick();

    // Reset and start together: reset wins
    applyStimulus(8'h12, 8'h34, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start2 = 1'b0;
    checkOutput("reset_beats_start", 32'(busy2), 32'd0);
    tick();
    checkOutput("reset_beats_start_idle", 32'({busy2, done2}), 32'd0);

    // Randomised NIBBLES=1
    for (int i = 0; i < 1000; i++) begin
      na = 4'($urandom());
      nb = 4'($urandom());
      vc = 1'($urandom());
      if (i % 16 == 0) begin
        na = 4'hF;
        nb = 4'hF;
      end
      runAdd1(na, nb, vc, full1, lat);
      checkOutput($sformatf("rand1_sum_%0d", i), 32'(full1), 32'(5'(na) + 5'(nb) + 5'(vc)));
      checkOutput($sformatf("rand1_lat_%0d", i), 32'(lat), 32'd2);
    end
    tick();

    // Randomised NIBBLES=4
    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom());
      wb = 16'($urandom());
      vc = 1'($urandom());
      if (i % 16 == 0) begin
        wa = 16'hFFFF;
        wb = 16'(i / 16);
      end
      runAdd4(wa, wb, vc, full4, lat);
      checkOutput($sformatf("rand4_sum_%0d", i), 32'(full4), 32'(17'(wa) + 17'(wb) + 17'(vc)));
      checkOutput($sformatf("rand4_lat_%0d", i), 32'(lat), 32'd5);
    end
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
